cam_frame_writer: RTL and testbench
===================================

// Module: cam_frame_writer
// PURPOSE
//   Downstream stage of the OV7670 RGB565->RGB332 converter: takes each converted 8-bit
//   pixel plus its write strobe and writes it to the frame-buffer RAM.
//   Generates a raster-ordered write address from the vsync/href framing.
//   Clips out-of-window pixels and lines, and reports frame completion and short frames.
// PARAMETERS
//   WIDTH   160  active pixels per line stored (QQVGA)
//   HEIGHT  120  active lines per frame stored
//   AW      15   RAM address width; must satisfy 2**AW >= WIDTH*HEIGHT
//   DW      8    pixel width (RGB332)
// PORTS
//   pclk        in   1   camera pixel clock; all logic on rising edge
//   in_reset    in   1   asynchronous, active-high reset
//   vsync       in   1   camera vsync; high = vertical blanking
//   href        in   1   camera href; high = active line
//   px_data     in   DW  converted pixel from upstream converter
//   px_valid    in   1   upstream write strobe; one pixel per pclk cycle where high
//   cap_en      in   1   level; arms capture
//   cont_mode   in   1   1 = capture frames back-to-back, 0 = single frame
//   mem_addr    out  AW  RAM write address
//   mem_data    out  DW  RAM write data
//   mem_we      out  1   RAM write enable, one cycle per stored pixel
//   frame_done  out  1   one-cycle pulse at end of a captured frame
//   busy        out  1   high in WAIT_VS and CAPTURE
//   err_short   out  1   sticky; frame ended with fewer than HEIGHT lines; cleared on entering CAPTURE
// BEHAVIOUR
//   Reset: state=IDLE; mem_addr=0, mem_data=0, mem_we=0, frame_done=0, busy=0, err_short=0;
//     col=0, row=0, addr counter=0; edge-detect history regs=0 (vsync_q, href_q).
//   Edge detect: vsync_q/href_q are 1-cycle delayed copies.
//     rise = x & ~x_q; fall = ~x & x_q.
//   FSM:
//     IDLE    -> WAIT_VS when cap_en=1.
//     WAIT_VS -> CAPTURE on vsync fall. On entry: col=0, row=0, addr=0, err_short=0.
//     CAPTURE -> DONE on vsync rise.
//     DONE    -> (one cycle, frame_done=1) -> WAIT_VS if cont_mode & cap_en, else IDLE.
//   cap_en dropping mid-CAPTURE does not abort; the frame completes, then FSM goes to IDLE.
//   Pixel accept (CAPTURE only): px_valid=1, regardless of href. Upstream emits the last
//     pixel after href falls.
//     If col<WIDTH and row<HEIGHT: mem_we=1, mem_data=px_data, mem_addr=addr; then addr++, col++.
//     Otherwise the pixel is dropped, mem_we=0, and col saturates at WIDTH.
//   Latency: mem_* registered; mem_we asserted in the cycle after the accepting edge.
//     mem_we=0 in every other cycle.
//   Line advance: on href rise in CAPTURE with col!=0: row++, col=0.
//     addr += (WIDTH - col) for short lines, so every line starts at row*WIDTH. No multiplier.
//     href rise with col==0 (empty line) leaves row and addr unchanged.
//   Simultaneous px_valid and href rise: the pixel is stored at the current line end
//     first, then the line advances.
//   Row saturates at HEIGHT; mem_addr never exceeds WIDTH*HEIGHT-1.
//   Frame end (vsync rise in CAPTURE): lines = row + (col!=0).
//     err_short=1 if lines<HEIGHT. A px_valid in this same cycle is still accepted.
//   vsync rise outside CAPTURE is ignored. In WAIT_VS, a frame already in progress is
//     skipped until the next vsync fall.
//   in_reset mid-frame: immediate return to reset values; the partial frame is abandoned.
// STRUCTURE
//   cam_pkg: state encoding (IDLE, WAIT_VS, CAPTURE, DONE), QQVGA_W=160, QQVGA_H=120,
//     FB_AW=15.
//   Sub-module edge_det: 1-bit register plus rise/fall outputs, same pclk/in_reset;
//     instantiated for vsync and href.
//   Top holds the FSM, col/row/addr counters and output registers.
// TESTING
//   T1 full frame: 120 lines x 160 px -> 19200 mem_we pulses, addr 0..19199 in order,
//      frame_done once, err_short=0.
//   T2 long line: 200 px in line 0 -> px 160..199 dropped; line 1 px0 at addr 160.
//   T3 short frame: vsync rise after 50 lines -> frame_done pulse, err_short=1, FSM to IDLE
//      (cont_mode=0).
//   T4 short line: 100 px in line 3 -> line 4 px0 written at addr 640.
//   T5 last pixel on href rise: px_valid in the same cycle as href rise -> stored at
//      prior line end, next px at row*160.
//   T6 reset mid-frame at addr 5000 -> all outputs 0, IDLE; with cap_en=1, the next
//      capture starts at addr 0 after vsync fall.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and geometry for the camera frame-buffer writer.
// The state encoding and QQVGA frame sizes are used by the writer and by anything that inspects it.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cam_state_t;

    localparam int QQVGA_W = 160;
    localparam int QQVGA_H = 120;
    localparam int FB_AW   = 15;

endpackage

// File: rtl/cam_frame_writer_edge_det.sv
// One-bit history register with combinational rise/fall strobes.
// Used on the camera vsync and href framing signals.
module edge_det (
    input  logic pclk,
    input  logic in_reset,
    input  logic x,
    output logic rise,
    output logic fall
);

    logic x_q;

    always_ff @(posedge pclk or posedge in_reset) begin
        if (in_reset) begin
            x_q <= 1'b0;
        end else begin
            x_q <= x;
        end
    end

    assign rise = x & ~x_q;
    assign fall = ~x & x_q;

endmodule

// File: rtl/cam_frame_writer.sv
// Writes converted RGB332 pixels into a raster-ordered frame buffer, clipping to WIDTH x HEIGHT
// and flagging frames that end with too few lines.
module cam_frame_writer
    import cam_pkg::*;
#(
    parameter int WIDTH  = QQVGA_W,
    parameter int HEIGHT = QQVGA_H,
    parameter int AW     = FB_AW,
    parameter int DW     = 8
) (
    input  logic          pclk,
    input  logic          in_reset,
    input  logic          vsync,
    input  logic          href,
    input  logic [DW-1:0] px_data,
    input  logic          px_valid,
    input  logic          cap_en,
    input  logic          cont_mode,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_we,
    output logic          frame_done,
    output logic          busy,
    output logic          err_short
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(HEIGHT + 1);

    // Index 0 is vsync, index 1 is href.
    logic [1:0] sync_in;
    logic [1:0] sync_rise;
    logic [1:0] sync_fall;
    logic       unused_href_fall;

    assign sync_in          = {href, vsync};
    assign unused_href_fall = sync_fall[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            edge_det u_edge_det (
                .pclk     (pclk),
                .in_reset (in_reset),
                .x        (sync_in[gi]),
                .rise     (sync_rise[gi]),
                .fall     (sync_fall[gi])
            );
        end
    endgenerate

    logic vs_rise, vs_fall, hr_rise;
    assign vs_rise = sync_rise[0];
    assign vs_fall = sync_fall[0];
    assign hr_rise = sync_rise[1];

    cam_state_t    state_reg, state_next;
    logic [CW-1:0] col_reg, col_next, col_px;
    logic [RW-1:0] row_reg, row_next;
    logic [AW-1:0] addr_reg, addr_next, addr_px;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic [DW-1:0] mem_data_reg, mem_data_next;
    logic          mem_we_reg, mem_we_next;
    logic          frame_done_reg, busy_reg;
    logic          err_short_reg, err_short_next;
    logic          accept;
    logic [RW:0]   lines;

    always_comb begin
        state_next     = state_reg;
        col_next       = col_reg;
        row_next       = row_reg;
        addr_next      = addr_reg;
        err_short_next = err_short_reg;
        mem_we_next    = 1'b0;
        mem_data_next  = mem_data_reg;
        mem_addr_next  = mem_addr_reg;
        accept         = 1'b0;
        col_px         = col_reg;
        addr_px        = addr_reg;
        lines          = '0;

        case (state_reg)
            IDLE: begin
                if (cap_en) begin
                    state_next = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (vs_fall) begin
                    state_next     = CAPTURE;
                    col_next       = '0;
                    row_next       = '0;
                    addr_next      = '0;
                    err_short_next = 1'b0;
                end
            end
            CAPTURE: begin
                accept = px_valid && (col_reg < CW'(WIDTH)) && (row_reg < RW'(HEIGHT));
                if (accept) begin
                    mem_we_next   = 1'b1;
                    mem_data_next = px_data;
                    mem_addr_next = addr_reg;
                    col_px        = col_reg + CW'(1);
                    addr_px       = addr_reg + AW'(1);
                end
                col_next  = col_px;
                addr_next = addr_px;

                // A pixel arriving with href rise belongs to the old line, so the
                // advance works on the post-pixel column; padding lands on row*WIDTH.
                if (hr_rise && (col_px != '0)) begin
                    col_next = '0;
                    if (row_reg < RW'(HEIGHT)) begin
                        row_next  = row_reg + RW'(1);
                        addr_next = addr_px + (AW'(WIDTH) - AW'(col_px));
                    end
                end

                if (vs_rise) begin
                    state_next     = DONE;
                    lines          = {1'b0, row_next} + (RW + 1)'(col_next != '0);
                    err_short_next = (lines < (RW + 1)'(HEIGHT));
                end
            end
            DONE: begin
                state_next = (cont_mode && cap_en) ? WAIT_VS : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge in_reset) begin
        if (in_reset) begin
            state_reg      <= IDLE;
            col_reg        <= '0;
            row_reg        <= '0;
            addr_reg       <= '0;
            mem_addr_reg   <= '0;
            mem_data_reg   <= '0;
            mem_we_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            busy_reg       <= 1'b0;
            err_short_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            col_reg        <= col_next;
            row_reg        <= row_next;
            addr_reg       <= addr_next;
            mem_addr_reg   <= mem_addr_next;
            mem_data_reg   <= mem_data_next;
            mem_we_reg     <= mem_we_next;
            frame_done_reg <= (state_next == DONE);
            busy_reg       <= (state_next == WAIT_VS) || (state_next == CAPTURE);
            err_short_reg  <= err_short_next;
        end
    end

    assign mem_addr   = mem_addr_reg;
    assign mem_data   = mem_data_reg;
    assign mem_we     = mem_we_reg;
    assign frame_done = frame_done_reg;
    assign busy       = busy_reg;
    assign err_short  = err_short_reg;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench for cam_frame_writer: drives vsync/href/pixel framing and checks the
// logged RAM writes, frame_done pulses and status flags against hand-derived values.
module tb_cam_frame_writer;

    logic        pclk;
    logic        in_reset;
    logic        vsync;
    logic        href;
    logic [7:0]  px_data;
    logic        px_valid;
    logic        cap_en;
    logic        cont_mode;
    logic [14:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic        frame_done;
    logic        busy;
    logic        err_short;

    int vectors;
    int miscompares;
    int fd_cnt;
    logic [14:0] log_addr[$];
    logic [7:0]  log_data[$];

    cam_frame_writer dut (
        .pclk       (pclk),
        .in_reset   (in_reset),
        .vsync      (vsync),
        .href       (href),
        .px_data    (px_data),
        .px_valid   (px_valid),
        .cap_en     (cap_en),
        .cont_mode  (cont_mode),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .frame_done (frame_done),
        .busy       (busy),
        .err_short  (err_short)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Write/pulse monitor on the falling edge, away from the active edge.
    always @(negedge pclk) begin
        if (mem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_data);
        end
        if (frame_done) fd_cnt++;
    end

    function automatic logic [7:0] pat(input int line, input int c);
        return 8'((line * 37 + c * 3) ^ 8'h5A);
    endfunction

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        fd_cnt = 0;
    endtask

    task automatic start_frame(input bit keep_en);
        cap_en = 1'b1;
        step(1);
        vsync = 1'b1;
        step(3);
        vsync = 1'b0;
        step(2);
        if (!keep_en) cap_en = 1'b0;
    endtask

    task automatic end_frame();
        vsync = 1'b1;
        step(4);
    endtask

    task automatic send_line(input int line, input int n);
        href = 1'b1;
        step(1);
        for (int c = 0; c < n; c++) begin
            px_valid = 1'b1;
            px_data  = pat(line, c);
            step(1);
        end
        px_valid = 1'b0;
        href     = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        in_reset = 1'b1;
        step(2);
        vectors++;
        if ({mem_addr, mem_data, mem_we, frame_done, busy, err_short} !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got addr=%0d data=%0d we=%0b fd=%0b busy=%0b err=%0b required all 0",
                     mem_addr, mem_data, mem_we, frame_done, busy, err_short);
        end
        in_reset = 1'b0;
        step(2);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_busy: got %0b required 0", busy);
        end
    endtask

    task automatic test_full_frame();
        int first_bad;
        clear_log();
        start_frame(1'b0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL t1_busy_capture: got %0b required 1", busy);
        end
        for (int l = 0; l < 120; l++) send_line(l, 160);
        end_frame();
        vectors++;
        if (log_addr.size() !== 19200) begin
            miscompares++;
            $display("FAIL t1_write_count: got %0d required 19200", log_addr.size());
        end
        first_bad = -1;
        for (int i = 0; i < log_addr.size(); i++) begin
            if (first_bad < 0 && (log_addr[i] !== 15'(i) || log_data[i] !== pat(i / 160, i % 160)))
                first_bad = i;
        end
        vectors++;
        if (first_bad !== -1) begin
            miscompares++;
            $display("FAIL t1_addr_order: entry %0d got addr=%0d data=%0h required addr=%0d data=%0h",
                     first_bad, log_addr[first_bad], log_data[first_bad], first_bad,
                     pat(first_bad / 160, first_bad % 160));
        end
        vectors++;
        if (fd_cnt !== 1) begin
            miscompares++;
            $display("FAIL t1_frame_done: got %0d pulses required 1", fd_cnt);
        end
        vectors++;
        if ({err_short, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL t1_status: got err=%0b busy=%0b required err=0 busy=0", err_short, busy);
        end
    endtask

    task automatic test_long_line();
        clear_log();
        start_frame(1'b0);
        send_line(0, 200);
        send_line(1, 10);
        end_frame();
        vectors++;
        if (log_addr.size() !== 170) begin
            miscompares++;
            $display("FAIL t2_write_count: got %0d required 170", log_addr.size());
        end
        vectors++;
        if (log_addr[159] !== 15'd159 || log_data[159] !== pat(0, 159)) begin
            miscompares++;
            $display("FAIL t2_line0_end: got addr=%0d data=%0h required addr=159 data=%0h",
                     log_addr[159], log_data[159], pat(0, 159));
        end
        vectors++;
        if (log_addr[160] !== 15'd160 || log_data[160] !== pat(1, 0)) begin
            miscompares++;
            $display("FAIL t2_line1_px0: got addr=%0d data=%0h required addr=160 data=%0h",
                     log_addr[160], log_data[160], pat(1, 0));
        end
    endtask

    task automatic test_short_frame();
        clear_log();
        start_frame(1'b0);
        for (int l = 0; l < 50; l++) send_line(l, 160);
        end_frame();
        vectors++;
        if (log_addr.size() !== 8000 || log_addr[7999] !== 15'd7999) begin
            miscompares++;
            $display("FAIL t3_writes: got count=%0d last=%0d required count=8000 last=7999",
                     log_addr.size(), log_addr[7999]);
        end
        vectors++;
        if (fd_cnt !== 1) begin
            miscompares++;
            $display("FAIL t3_frame_done: got %0d pulses required 1", fd_cnt);
        end
        vectors++;
        if ({err_short, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL t3_status: got err=%0b busy=%0b required err=1 busy=0", err_short, busy);
        end
    endtask

    task automatic test_short_line();
        clear_log();
        start_frame(1'b0);
        for (int l = 0; l < 3; l++) send_line(l, 160);
        send_line(3, 100);
        send_line(4, 5);
        end_frame();
        vectors++;
        if (log_addr.size() !== 585) begin
            miscompares++;
            $display("FAIL t4_write_count: got %0d required 585", log_addr.size());
        end
        vectors++;
        if (log_addr[579] !== 15'd579) begin
            miscompares++;
            $display("FAIL t4_line3_end: got addr=%0d required 579", log_addr[579]);
        end
        vectors++;
        if (log_addr[580] !== 15'd640 || log_data[580] !== pat(4, 0)) begin
            miscompares++;
            $display("FAIL t4_line4_px0: got addr=%0d data=%0h required addr=640 data=%0h",
                     log_addr[580], log_data[580], pat(4, 0));
        end
    endtask

    task automatic test_px_on_href_rise();
        clear_log();
        start_frame(1'b0);
        send_line(0, 159);
        // Final pixel of line 0 arrives in the same cycle as the href rise of line 1.
        href     = 1'b1;
        px_valid = 1'b1;
        px_data  = 8'hA5;
        step(1);
        for (int c = 0; c < 4; c++) begin
            px_data = pat(1, c);
            step(1);
        end
        px_valid = 1'b0;
        href     = 1'b0;
        step(2);
        end_frame();
        vectors++;
        if (log_addr[159] !== 15'd159 || log_data[159] !== 8'hA5) begin
            miscompares++;
            $display("FAIL t5_tail_px: got addr=%0d data=%0h required addr=159 data=a5",
                     log_addr[159], log_data[159]);
        end
        vectors++;
        if (log_addr[160] !== 15'd160 || log_data[160] !== pat(1, 0) || log_addr.size() !== 164) begin
            miscompares++;
            $display("FAIL t5_next_line: got addr=%0d data=%0h count=%0d required addr=160 data=%0h count=164",
                     log_addr[160], log_data[160], log_addr.size(), pat(1, 0));
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        cont_mode = 1'b1;
        start_frame(1'b1);
        send_line(0, 3);
        send_line(1, 3);
        end_frame();
        vectors++;
        if ({busy, err_short} !== 2'b11) begin
            miscompares++;
            $display("FAIL b2b_rearmed: got busy=%0b err=%0b required busy=1 err=1", busy, err_short);
        end
        vsync = 1'b0;
        step(2);
        vectors++;
        if (err_short !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_err_clear: got %0b required 0", err_short);
        end
        send_line(0, 3);
        cap_en = 1'b0;
        send_line(1, 3);
        end_frame();
        vectors++;
        if (log_addr.size() !== 12 || log_addr[6] !== 15'd0 || log_addr[9] !== 15'd160) begin
            miscompares++;
            $display("FAIL b2b_frame2_addr: got count=%0d a6=%0d a9=%0d required 12/0/160",
                     log_addr.size(), log_addr[6], log_addr[9]);
        end
        vectors++;
        if (fd_cnt !== 2 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done: got pulses=%0d busy=%0b required pulses=2 busy=0", fd_cnt, busy);
        end
        cont_mode = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        clear_log();
        start_frame(1'b1);
        for (int l = 0; l < 31; l++) send_line(l, 160);
        href = 1'b1;
        step(1);
        for (int c = 0; c < 40; c++) begin
            px_valid = 1'b1;
            px_data  = pat(31, c);
            step(1);
        end
        px_valid = 1'b0;
        step(1);
        vectors++;
        if (log_addr.size() !== 5000 || log_addr[4999] !== 15'd4999) begin
            miscompares++;
            $display("FAIL t6_pre_reset: got count=%0d last=%0d required 5000/4999",
                     log_addr.size(), log_addr[4999]);
        end
        #2;
        in_reset = 1'b1;
        #1;
        vectors++;
        if ({mem_addr, mem_data, mem_we, frame_done, busy, err_short} !== 27'd0) begin
            miscompares++;
            $display("FAIL t6_async_reset: got addr=%0d data=%0h we=%0b fd=%0b busy=%0b err=%0b required all 0",
                     mem_addr, mem_data, mem_we, frame_done, busy, err_short);
        end
        href  = 1'b0;
        vsync = 1'b0;
        step(2);
        in_reset = 1'b0;
        clear_log();
        start_frame(1'b0);
        send_line(0, 5);
        end_frame();
        vectors++;
        if (log_addr.size() !== 5 || log_addr[0] !== 15'd0 || log_addr[4] !== 15'd4) begin
            miscompares++;
            $display("FAIL t6_restart: got count=%0d first=%0d last=%0d required 5/0/4",
                     log_addr.size(), log_addr[0], log_addr[4]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        fd_cnt      = 0;
        in_reset    = 1'b1;
        vsync       = 1'b0;
        href        = 1'b0;
        px_data     = 8'd0;
        px_valid    = 1'b0;
        cap_en      = 1'b0;
        cont_mode   = 1'b0;

        test_reset();
        test_full_frame();
        test_long_line();
        test_short_frame();
        test_short_line();
        test_px_on_href_rise();
        test_back_to_back();
        test_reset_mid_frame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
